// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: start handshake, transmit fields and serial outputs of seq_pattern_tx.
//   master: start_valid, pattern, repeat_cnt, gap_len, abort out; start_ready, dout,
//           dout_valid, busy, done, aborted in
//   slave : the reverse (the transmitter side)
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             abort;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start_valid, pattern, repeat_cnt, gap_len, abort,
        input  start_ready, dout, dout_valid, busy, done, aborted
    );

    modport slave (
        input  start_valid, pattern, repeat_cnt, gap_len, abort,
        output start_ready, dout, dout_valid, busy, done, aborted
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: sends a latched pattern MSB-first, repeat_cnt times with gap_len idle bits between.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of seq_pattern_tx_if (start handshake, fields, abort, serial outputs)
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input logic             clk,
    input logic             reset_n,
    seq_pattern_tx_if.slave bus
);
    localparam int IW = $clog2(PAT_W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IW-1:0]    bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             aborted_q, aborted_d;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bit_idx_d = bit_idx_q;
        reps_d    = reps_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                aborted_d = 1'b0;
                if (bus.start_valid) begin
                    pat_d     = bus.pattern;
                    reps_d    = bus.repeat_cnt;
                    gap_len_d = bus.gap_len;
                    bit_idx_d = IW'(PAT_W - 1);
                    state_d   = (bus.repeat_cnt == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (bus.abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (bit_idx_q == '0) begin
                    // Last bit of this repetition: finish, restart without bubble, or idle for the gap.
                    reps_d    = reps_q - 1'b1;
                    bit_idx_d = IW'(PAT_W - 1);
                    gap_cnt_d = gap_len_q;
                    state_d   = (reps_q == CNT_W'(1)) ? DONE : (gap_len_q == '0) ? SEND : GAP;
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = SEND;
                    bit_idx_d = IW'(PAT_W - 1);
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            bit_idx_q <= '0;
            reps_q    <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            bit_idx_q <= bit_idx_d;
            reps_q    <= reps_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.start_ready = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.dout_valid  = state_q == SEND;
    assign bus.dout        = (state_q == SEND) & pat_q[bit_idx_q];
    assign bus.done        = state_q == DONE;
    assign bus.aborted     = (state_q == DONE) & aborted_q;
endmodule
